// File: rtl/sparse_stream_pkg.sv
// ============================================================================
// Module      : sparse_stream_pkg
// Description : Shared stream-word encoding, token helpers and the densifier
//               FSM state type for the sparse stream fabric primitives.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sparse_stream_pkg;

  // Stream word: bit 16 flags a control word, [15:0] carries the payload.
  localparam int STREAM_W = 17;
  localparam int CTRL_BIT = 16;

  // Control-word kind lives in [9:8]; stop tokens carry their level in [7:0].
  localparam logic [1:0] CTRL_STOP = 2'b00;
  localparam logic [1:0] CTRL_DONE = 2'b01;

  localparam logic [STREAM_W-1:0] STOP_BASE  = 17'h10000;
  localparam logic [STREAM_W-1:0] DONE_TOKEN = 17'h10100;

  typedef enum logic [1:0] {
    ST_DATA  = 2'd0,
    ST_TAIL  = 2'd1,
    ST_TOKEN = 2'd2,
    ST_FIN   = 2'd3
  } densify_state_t;

  function automatic logic is_ctrl(input logic [STREAM_W-1:0] w);
    return w[CTRL_BIT];
  endfunction

  function automatic logic is_stop(input logic [STREAM_W-1:0] w);
    return w[CTRL_BIT] && (w[9:8] == CTRL_STOP);
  endfunction

  function automatic logic is_done(input logic [STREAM_W-1:0] w);
    return w[CTRL_BIT] && (w[9:8] == CTRL_DONE);
  endfunction

  function automatic logic [7:0] stop_level(input logic [STREAM_W-1:0] w);
    return w[7:0];
  endfunction

  function automatic logic [STREAM_W-1:0] make_stop(input logic [7:0] level);
    return STOP_BASE | {9'd0, level};
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_out_reg.sv
// ============================================================================
// Module      : stream_out_reg
// Description : One-entry ready/valid output register. Accepts a new word
//               whenever it is empty or its current word is being taken, so
//               it sustains one word per cycle with no bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_out_reg #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] in_data,
  input  logic         in_push,
  input  logic         out_ready,
  output logic         can_load,
  output logic [W-1:0] out_data,
  output logic         out_valid
);

  assign can_load = !out_valid || out_ready;

  // Hold the word until taken; data only changes on a push so it is stable
  // for as long as the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (en && can_load) begin
      out_valid <= in_push;
      if (in_push) begin
        out_data <= in_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/crd_densify.sv
// ============================================================================
// Module      : crd_densify
// Description : Sparse-to-dense decompressor. Merges a sorted coordinate
//               stream with its value stream and emits every fiber as exactly
//               DIM data words (zero-filled), followed by the regenerated stop
//               token, and finally the done token.
// Options     : CRD_DENSIFY_PERF_EN adds the pad_count output, a saturating
//               count of zero-fill words taken by the consumer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crd_densify
  import sparse_stream_pkg::*;
#(
  parameter int DIM    = 16,
  parameter int DATA_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  logic            flush,
  input  logic            tile_en,
  input  logic [DATA_W:0] crd_in,
  input  logic            crd_in_valid,
  output logic            crd_in_ready,
  input  logic [DATA_W:0] val_in,
  input  logic            val_in_valid,
  output logic            val_in_ready,
  output logic [DATA_W:0] dense_out,
  output logic            dense_out_valid,
  input  logic            dense_out_ready,
  output logic            err
`ifdef CRD_DENSIFY_PERF_EN
  ,
  output logic [31:0]     pad_count
`endif
);

  localparam logic [15:0] DIM16 = 16'(DIM);

`ifdef CRD_DENSIFY_PERF_EN
  // The output register carries a side bit marking zero-fill words.
  localparam int OUT_W = STREAM_W + 1;
`else
  localparam int OUT_W = STREAM_W;
`endif

  densify_state_t        state;
  densify_state_t        state_nx;
  logic [15:0]           idx;
  logic [15:0]           idx_nx;
  logic                  emit;
  logic [STREAM_W-1:0]   emit_word;
  logic                  consume;
  logic                  set_err;
  logic                  both_valid;
  logic                  crd_ctrl;
  logic                  val_ctrl;
  logic [15:0]           coord;
  logic                  can_load;
  logic                  go;
  logic                  out_valid_q;
  logic [OUT_W-1:0]      out_word;
  logic [OUT_W-1:0]      push_word;
`ifdef CRD_DENSIFY_PERF_EN
  logic                  emit_pad;
`endif

  assign both_valid = crd_in_valid && val_in_valid;
  assign crd_ctrl   = is_ctrl(crd_in);
  assign val_ctrl   = is_ctrl(val_in);
  assign coord      = crd_in[15:0];

  // A step happens only when the output register can take whatever this
  // state produces; flush wins over any step in the same enabled cycle.
  assign go = clk_en && tile_en && !flush && can_load;

  // Both streams advance together; readies stay low in reset.
  assign crd_in_ready = consume && go && !rst;
  assign val_in_ready = consume && go && !rst;

  // Decide what the current state emits, consumes and flags this cycle.
  always_comb begin
    emit      = 1'b0;
    emit_word = '0;
    consume   = 1'b0;
    set_err   = 1'b0;
    state_nx  = state;
    idx_nx    = idx;
`ifdef CRD_DENSIFY_PERF_EN
    emit_pad  = 1'b0;
`endif
    case (state)
      ST_DATA: begin
        if (both_valid) begin
          if (!crd_ctrl && !val_ctrl) begin
            if ((coord >= DIM16) || (coord < idx)) begin
              // Out-of-range or unsorted coordinate: drop the pair.
              set_err = 1'b1;
              consume = 1'b1;
            end else if (coord > idx) begin
              // Fill the gap ahead of the coordinate, keep it at the head.
              emit    = 1'b1;
              idx_nx  = idx + 16'd1;
`ifdef CRD_DENSIFY_PERF_EN
              emit_pad = 1'b1;
`endif
            end else begin
              emit      = 1'b1;
              emit_word = val_in;
              consume   = 1'b1;
              idx_nx    = idx + 16'd1;
            end
          end else if (crd_ctrl != val_ctrl) begin
            set_err = 1'b1;
            consume = 1'b1;
          end else if (is_stop(crd_in)) begin
            state_nx = ST_TAIL;
          end else if (is_done(crd_in)) begin
            if (idx == 16'd0) begin
              emit      = 1'b1;
              emit_word = DONE_TOKEN;
              consume   = 1'b1;
              state_nx  = ST_FIN;
              if (val_in != DONE_TOKEN) begin
                set_err = 1'b1;
              end
            end else begin
              // Unterminated fiber: close it with an implicit S0 first.
              set_err  = 1'b1;
              state_nx = ST_TAIL;
            end
          end else begin
            set_err = 1'b1;
            consume = 1'b1;
          end
        end
      end

      ST_TAIL: begin
        if (idx >= DIM16) begin
          state_nx = ST_TOKEN;
        end else begin
          emit   = 1'b1;
          idx_nx = idx + 16'd1;
`ifdef CRD_DENSIFY_PERF_EN
          emit_pad = 1'b1;
`endif
          if ((idx + 16'd1) == DIM16) begin
            state_nx = ST_TOKEN;
          end
        end
      end

      ST_TOKEN: begin
        if (both_valid) begin
          if (is_stop(crd_in)) begin
            emit      = 1'b1;
            emit_word = crd_in;
            consume   = 1'b1;
            idx_nx    = 16'd0;
            state_nx  = ST_DATA;
            if (val_in != crd_in) begin
              set_err = 1'b1;
            end
          end else if (is_done(crd_in)) begin
            // Implicit S0; the done token stays at the head for ST_DATA.
            emit      = 1'b1;
            emit_word = make_stop(8'd0);
            idx_nx    = 16'd0;
            state_nx  = ST_DATA;
          end else begin
            set_err = 1'b1;
            consume = 1'b1;
          end
        end
      end

      ST_FIN: begin
        state_nx = ST_FIN;
      end

      default: begin
        state_nx = ST_DATA;
      end
    endcase
  end

  // FSM state, position counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_DATA;
      idx   <= 16'd0;
      err   <= 1'b0;
    end else if (clk_en) begin
      if (flush) begin
        state <= ST_DATA;
        idx   <= 16'd0;
        err   <= 1'b0;
      end else if (go) begin
        state <= state_nx;
        idx   <= idx_nx;
        if (set_err) begin
          err <= 1'b1;
        end
      end
    end
  end

`ifdef CRD_DENSIFY_PERF_EN
  assign push_word = {emit_pad, emit_word};
`else
  assign push_word = emit_word;
`endif

  stream_out_reg #(
    .W (OUT_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .clr       (clk_en && flush),
    .en        (clk_en && tile_en),
    .in_data   (push_word),
    .in_push   (emit && go),
    .out_ready (dense_out_ready && tile_en),
    .can_load  (can_load),
    .out_data  (out_word),
    .out_valid (out_valid_q)
  );

  assign dense_out       = out_word[STREAM_W-1:0];
  assign dense_out_valid = out_valid_q && tile_en;

`ifdef CRD_DENSIFY_PERF_EN
  // Count zero-fill words as they are taken downstream, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_count <= 32'd0;
    end else if (clk_en) begin
      if (flush) begin
        pad_count <= 32'd0;
      end else if (dense_out_valid && dense_out_ready && out_word[STREAM_W]
                   && (pad_count != 32'hFFFF_FFFF)) begin
        pad_count <= pad_count + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
